// File: rtl/elite_spi_pkg.sv
// Shared definitions for the SPI command controller.
// Holds the controller state encoding, the bit positions of the read/write
// and auto-increment flags inside the command byte, and the byte returned
// to the SPI master when a register read times out.
package elite_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_WR_DATA  = 3'd2,
    ST_RD_REQ   = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_RD_READY = 3'd5,
    ST_ERR      = 3'd6
  } state_t;

  // Command byte layout: bit7 selects read (1) or write (0), bit6 enables
  // address auto-increment, the low ADDR_W bits carry the start address.
  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_AINC_BIT = 6;

  // Shifted out instead of real data when the register file never answers.
  localparam logic [7:0] ERR_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/elite_spi_cmd_ctrl_if.sv
// Bus bundle between the SPI slave byte engine / register file and the
// command controller.
//   slave  : view of the controller (consumes bytes, drives strobes)
//   master : view of the surrounding logic (drives bytes, consumes strobes)
// Signals: Csel_Active, Rx_Valid, Rx_Byte (byte engine -> controller);
// Tx_Load, Tx_Byte (controller -> byte engine); Reg_Wr_En, Reg_Rd_En,
// Reg_Addr, Reg_Wr_Data (controller -> registers); Reg_Rd_Data,
// Reg_Rd_Valid (registers -> controller); Busy, Err_Flag, Frame_Cnt status.
interface elite_spi_cmd_ctrl_if #(
  parameter int ADDR_W = 6
);

  logic              Csel_Active;
  logic              Rx_Valid;
  logic [7:0]        Rx_Byte;
  logic              Tx_Load;
  logic [7:0]        Tx_Byte;
  logic              Reg_Wr_En;
  logic              Reg_Rd_En;
  logic [ADDR_W-1:0] Reg_Addr;
  logic [7:0]        Reg_Wr_Data;
  logic [7:0]        Reg_Rd_Data;
  logic              Reg_Rd_Valid;
  logic              Busy;
  logic              Err_Flag;
  logic [7:0]        Frame_Cnt;

  modport slave (
    input  Csel_Active, Rx_Valid, Rx_Byte, Reg_Rd_Data, Reg_Rd_Valid,
    output Tx_Load, Tx_Byte, Reg_Wr_En, Reg_Rd_En, Reg_Addr, Reg_Wr_Data,
           Busy, Err_Flag, Frame_Cnt
  );

  modport master (
    output Csel_Active, Rx_Valid, Rx_Byte, Reg_Rd_Data, Reg_Rd_Valid,
    input  Tx_Load, Tx_Byte, Reg_Wr_En, Reg_Rd_En, Reg_Addr, Reg_Wr_Data,
           Busy, Err_Flag, Frame_Cnt
  );

endinterface

// File: rtl/elite_spi_timeout.sv
// Read-response watchdog.
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : restart the count from zero
//   enable     : count one waiting cycle
//   expire     : high during the LIMIT-th enabled cycle after a load
module elite_spi_timeout #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = enable && (cnt_q == LAST);

  // Saturates at LAST so a lingering enable cannot wrap and re-arm.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (enable && !expire) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/elite_spi_cmd_ctrl.sv
// SPI command controller: decodes the first byte of each SPI frame as a
// command, then turns subsequent bytes into register writes, or fetches
// register data for the byte engine to shift out.
//   MClk, MRst_n : system clock, asynchronous active-low reset
//   bus          : byte engine / register file bundle (slave view)
// All strobes and data outputs are registered.
module elite_spi_cmd_ctrl
  import elite_spi_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                 MClk,
  input  logic                 MRst_n,
  elite_spi_cmd_ctrl_if.slave  bus
);

  state_t            state_q, state_d;
  logic              csel_prev_q;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic              auto_inc_q, auto_inc_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              tx_load_q, tx_load_d;
  logic              err_q, err_d;
  logic              to_load, to_enable, to_expire;

  assign addr_inc  = addr_q + ADDR_W'(1);
  assign to_load   = (state_q == ST_RD_REQ);
  assign to_enable = (state_q == ST_RD_WAIT) && bus.Csel_Active;

  elite_spi_timeout #(.LIMIT(RD_TIMEOUT)) u_timeout (
    .clk    (MClk),
    .rst_n  (MRst_n),
    .load   (to_load),
    .enable (to_enable),
    .expire (to_expire)
  );

  always_ff @(posedge MClk or negedge MRst_n) begin
    if (!MRst_n) begin
      state_q     <= ST_IDLE;
      csel_prev_q <= 1'b0;
      addr_q      <= '0;
      auto_inc_q  <= 1'b0;
      wr_data_q   <= 8'h00;
      tx_byte_q   <= 8'h00;
      frame_cnt_q <= 8'h00;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      tx_load_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      csel_prev_q <= bus.Csel_Active;
      addr_q      <= addr_d;
      auto_inc_q  <= auto_inc_d;
      wr_data_q   <= wr_data_d;
      tx_byte_q   <= tx_byte_d;
      frame_cnt_q <= frame_cnt_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      tx_load_q   <= tx_load_d;
      err_q       <= err_d;
    end
  end

  // Frame end wins over everything, so a byte arriving as chip select
  // drops is discarded and any outstanding read is abandoned.
  always_comb begin
    state_d = state_q;
    if (!bus.Csel_Active) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (!csel_prev_q) state_d = ST_CMD;
        ST_CMD:      if (bus.Rx_Valid)
                       state_d = bus.Rx_Byte[CMD_RW_BIT] ? ST_RD_REQ : ST_WR_DATA;
        ST_WR_DATA:  state_d = ST_WR_DATA;
        ST_RD_REQ:   state_d = bus.Rx_Valid ? ST_ERR : ST_RD_WAIT;
        ST_RD_WAIT: begin
          if (bus.Rx_Valid)          state_d = ST_ERR;
          else if (bus.Reg_Rd_Valid) state_d = ST_RD_READY;
          else if (to_expire)        state_d = ST_ERR;
        end
        ST_RD_READY: if (bus.Rx_Valid) state_d = ST_RD_REQ;
        ST_ERR:      state_d = ST_ERR;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Write strobes go out with the address they were aimed at; the
  // auto-increment is applied during the strobe cycle so the next byte
  // lands one address higher.
  always_comb begin
    addr_d      = addr_q;
    auto_inc_d  = auto_inc_q;
    wr_data_d   = wr_data_q;
    tx_byte_d   = tx_byte_q;
    frame_cnt_d = frame_cnt_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    tx_load_d   = 1'b0;
    err_d       = err_q;
    if (wr_en_q && auto_inc_q) addr_d = addr_inc;
    if (bus.Csel_Active) begin
      case (state_q)
        ST_IDLE: begin
          if (!csel_prev_q) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            err_d       = 1'b0;
          end
        end
        ST_CMD: begin
          if (bus.Rx_Valid) begin
            addr_d     = bus.Rx_Byte[ADDR_W-1:0];
            auto_inc_d = bus.Rx_Byte[CMD_AINC_BIT];
          end
        end
        ST_WR_DATA: begin
          if (bus.Rx_Valid) begin
            wr_en_d   = 1'b1;
            wr_data_d = bus.Rx_Byte;
          end
        end
        ST_RD_REQ: begin
          if (bus.Rx_Valid) err_d   = 1'b1;
          else              rd_en_d = 1'b1;
        end
        ST_RD_WAIT: begin
          if (bus.Rx_Valid) begin
            err_d = 1'b1;
          end else if (bus.Reg_Rd_Valid) begin
            tx_byte_d = bus.Reg_Rd_Data;
            tx_load_d = 1'b1;
          end else if (to_expire) begin
            tx_byte_d = ERR_FILL_BYTE;
            tx_load_d = 1'b1;
            err_d     = 1'b1;
          end
        end
        ST_RD_READY: begin
          if (bus.Rx_Valid && auto_inc_q) addr_d = addr_inc;
        end
        default: ;
      endcase
    end
  end

  assign bus.Tx_Load     = tx_load_q;
  assign bus.Tx_Byte     = tx_byte_q;
  assign bus.Reg_Wr_En   = wr_en_q;
  assign bus.Reg_Rd_En   = rd_en_q;
  assign bus.Reg_Addr    = addr_q;
  assign bus.Reg_Wr_Data = wr_data_q;
  assign bus.Busy        = (state_q != ST_IDLE);
  assign bus.Err_Flag    = err_q;
  assign bus.Frame_Cnt   = frame_cnt_q;

endmodule

// File: tb/tb_elite_spi_cmd_ctrl.sv
// Self-checking bench for elite_spi_cmd_ctrl: a table of single-transaction
// frames followed by hand-written multi-cycle sequences (auto-increment
// writes, address wrap on reads, read timeout, overruns, frame aborts,
// frame counter wrap, asynchronous reset mid-frame).
module tb_elite_spi_cmd_ctrl;

  localparam int ADDR_W     = 6;
  localparam int RD_TIMEOUT = 64;

  typedef struct {
    logic [7:0]        cmd;
    logic [7:0]        data;
    logic              is_rd;
    logic [ADDR_W-1:0] exp_addr;
    logic [7:0]        exp_val;
  } vec_t;

  logic MClk;
  logic MRst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [7:0] exp_frames;

  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [7:0]        wr_data_log[$];
  logic [ADDR_W-1:0] rd_addr_log[$];
  logic [7:0]        tx_log[$];

  elite_spi_cmd_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  elite_spi_cmd_ctrl #(.ADDR_W(ADDR_W), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .MClk   (MClk),
    .MRst_n (MRst_n),
    .bus    (bus)
  );

  initial MClk = 1'b0;
  always #5 MClk = ~MClk;

  always @(posedge MClk) cyc <= cyc + 1;

  // Strobe recorder, sampled on the falling edge; also checks that no two
  // strobes are ever high together.
  always @(negedge MClk) begin
    if (bus.Reg_Wr_En) begin
      wr_addr_log.push_back(bus.Reg_Addr);
      wr_data_log.push_back(bus.Reg_Wr_Data);
    end
    if (bus.Reg_Rd_En) rd_addr_log.push_back(bus.Reg_Addr);
    if (bus.Tx_Load)   tx_log.push_back(bus.Tx_Byte);
    if (bus.Reg_Wr_En || bus.Reg_Rd_En || bus.Tx_Load) begin
      checks++;
      if ((2'(bus.Reg_Wr_En) + 2'(bus.Reg_Rd_En) + 2'(bus.Tx_Load)) != 2'd1) begin
        errors++;
        $display("[TB] FAIL strobe_exclusive: wr=%0b rd=%0b tx=%0b required at most one",
                 bus.Reg_Wr_En, bus.Reg_Rd_En, bus.Tx_Load);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge MClk);
    #1;
  endtask

  // Holds the given inputs for exactly one sampling edge; Rx_Valid is a
  // single-cycle strobe, so it is dropped afterwards.
  task automatic applyStimulus(input logic csel, input logic rxv, input logic [7:0] rxb);
    bus.Csel_Active = csel;
    bus.Rx_Valid    = rxv;
    bus.Rx_Byte     = rxb;
    tick();
    bus.Rx_Valid    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    applyStimulus(1'b1, 1'b1, b);
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic start_frame();
    applyStimulus(1'b1, 1'b0, 8'h00);
    exp_frames = exp_frames + 8'd1;
    tick();
  endtask

  task automatic end_frame();
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick();
    tick();
  endtask

  task automatic wait_rd_en(input string tag, output logic found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.Reg_Rd_En) found = 1'b1;
      else tick();
    end
    checkOutput({tag, "_rd_en_seen"}, 32'(found), 1);
  endtask

  task automatic respond(input string tag, input logic [7:0] rsp, input logic [7:0] exp_tx);
    checkOutput({tag, "_txload_pre"}, 32'(bus.Tx_Load), 0);
    bus.Reg_Rd_Valid = 1'b1;
    bus.Reg_Rd_Data  = rsp;
    tick();
    bus.Reg_Rd_Valid = 1'b0;
    checkOutput({tag, "_txload"}, 32'(bus.Tx_Load), 1);
    checkOutput({tag, "_txbyte"}, 32'(bus.Tx_Byte), 32'(exp_tx));
    tick();
    checkOutput({tag, "_txload_width"}, 32'(bus.Tx_Load), 0);
  endtask

  vec_t vecs[7];

  initial begin
    int   wb, rb, tb0, c0;
    logic found;
    logic [7:0] need;

    vecs[0] = '{8'h45, 8'hA5, 1'b0, 6'd5,  8'hA5};
    vecs[1] = '{8'h00, 8'h12, 1'b0, 6'd0,  8'h12};
    vecs[2] = '{8'h3F, 8'h7E, 1'b0, 6'd63, 8'h7E};
    vecs[3] = '{8'h9A, 8'h5C, 1'b1, 6'd26, 8'h5C};
    vecs[4] = '{8'hC7, 8'h00, 1'b1, 6'd7,  8'h00};
    vecs[5] = '{8'h2A, 8'hFF, 1'b0, 6'd42, 8'hFF};
    vecs[6] = '{8'hBF, 8'h3C, 1'b1, 6'd63, 8'h3C};

    exp_frames       = 8'h00;
    MRst_n           = 1'b0;
    bus.Csel_Active  = 1'b0;
    bus.Rx_Valid     = 1'b0;
    bus.Rx_Byte      = 8'h00;
    bus.Reg_Rd_Data  = 8'h00;
    bus.Reg_Rd_Valid = 1'b0;
    tick();
    tick();
    checkOutput("rst_busy",      32'(bus.Busy),        0);
    checkOutput("rst_err",       32'(bus.Err_Flag),    0);
    checkOutput("rst_frame_cnt", 32'(bus.Frame_Cnt),   0);
    checkOutput("rst_tx_byte",   32'(bus.Tx_Byte),     0);
    checkOutput("rst_addr",      32'(bus.Reg_Addr),    0);
    checkOutput("rst_wr_data",   32'(bus.Reg_Wr_Data), 0);
    checkOutput("rst_strobes",   32'({bus.Reg_Wr_En, bus.Reg_Rd_En, bus.Tx_Load}), 0);
    MRst_n = 1'b1;
    tick();

    $display("[TB] table vectors");
    for (int i = 0; i < 7; i++) begin
      wb  = wr_addr_log.size();
      rb  = rd_addr_log.size();
      tb0 = tx_log.size();
      start_frame();
      checkOutput("vec_frame_cnt", 32'(bus.Frame_Cnt), 32'(exp_frames));
      checkOutput("vec_busy", 32'(bus.Busy), 1);
      if (!vecs[i].is_rd) begin
        send_byte(vecs[i].cmd, 3);
        send_byte(vecs[i].data, 3);
        checkOutput("vec_wr_count", 32'(wr_addr_log.size() - wb), 1);
        if (wr_addr_log.size() > wb) begin
          checkOutput("vec_wr_addr", 32'(wr_addr_log[wb]), 32'(vecs[i].exp_addr));
          checkOutput("vec_wr_data", 32'(wr_data_log[wb]), 32'(vecs[i].exp_val));
        end
        checkOutput("vec_wr_no_rd", 32'(rd_addr_log.size() - rb), 0);
      end else begin
        send_byte(vecs[i].cmd, 0);
        wait_rd_en("vec", found);
        checkOutput("vec_rd_addr", 32'(bus.Reg_Addr), 32'(vecs[i].exp_addr));
        tick(); tick(); tick();
        respond("vec", vecs[i].data, vecs[i].exp_val);
        checkOutput("vec_rd_count", 32'(rd_addr_log.size() - rb), 1);
        checkOutput("vec_rd_no_wr", 32'(wr_addr_log.size() - wb), 0);
        checkOutput("vec_tx_count", 32'(tx_log.size() - tb0), 1);
      end
      checkOutput("vec_err", 32'(bus.Err_Flag), 0);
      end_frame();
      checkOutput("vec_idle", 32'(bus.Busy), 0);
    end

    $display("[TB] auto-increment write burst");
    wb = wr_addr_log.size();
    start_frame();
    send_byte(8'h45, 3);
    send_byte(8'hA5, 3);
    send_byte(8'h3C, 3);
    end_frame();
    checkOutput("burst_wr_count", 32'(wr_addr_log.size() - wb), 2);
    if (wr_addr_log.size() >= wb + 2) begin
      checkOutput("burst_addr0", 32'(wr_addr_log[wb]),     5);
      checkOutput("burst_data0", 32'(wr_data_log[wb]),     32'hA5);
      checkOutput("burst_addr1", 32'(wr_addr_log[wb + 1]), 6);
      checkOutput("burst_data1", 32'(wr_data_log[wb + 1]), 32'h3C);
    end
    checkOutput("burst_err", 32'(bus.Err_Flag), 0);

    $display("[TB] read burst with address wrap");
    start_frame();
    send_byte(8'hFF, 0);
    wait_rd_en("wrap0", found);
    checkOutput("wrap_addr0", 32'(bus.Reg_Addr), 63);
    tick(); tick(); tick();
    respond("wrap0", 8'h11, 8'h11);
    send_byte(8'h00, 0);
    wait_rd_en("wrap1", found);
    checkOutput("wrap_addr1", 32'(bus.Reg_Addr), 0);
    tick(); tick(); tick();
    respond("wrap1", 8'h22, 8'h22);
    checkOutput("wrap_err", 32'(bus.Err_Flag), 0);
    end_frame();

    $display("[TB] read without increment, then abandoned read");
    tb0 = tx_log.size();
    start_frame();
    send_byte(8'hBF, 0);
    wait_rd_en("same0", found);
    tick(); tick();
    respond("same0", 8'h33, 8'h33);
    send_byte(8'h00, 0);
    wait_rd_en("same1", found);
    checkOutput("same_addr1", 32'(bus.Reg_Addr), 63);
    bus.Csel_Active = 1'b0;
    tick();
    tick();
    bus.Reg_Rd_Valid = 1'b1;
    bus.Reg_Rd_Data  = 8'h44;
    tick();
    bus.Reg_Rd_Valid = 1'b0;
    tick(); tick();
    checkOutput("abandon_tx_count", 32'(tx_log.size() - tb0), 1);
    checkOutput("abandon_busy", 32'(bus.Busy), 0);
    checkOutput("abandon_err", 32'(bus.Err_Flag), 0);

    $display("[TB] read timeout");
    start_frame();
    send_byte(8'h82, 0);
    wait_rd_en("tmo", found);
    c0 = cyc;
    checkOutput("tmo_addr", 32'(bus.Reg_Addr), 2);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (bus.Tx_Load) found = 1'b1;
      else tick();
    end
    checkOutput("tmo_txload_seen", 32'(found), 1);
    checkOutput("tmo_latency", 32'(cyc - c0), 64);
    checkOutput("tmo_txbyte", 32'(bus.Tx_Byte), 32'hFF);
    checkOutput("tmo_err", 32'(bus.Err_Flag), 1);
    tick();
    wb  = wr_addr_log.size();
    rb  = rd_addr_log.size();
    tb0 = tx_log.size();
    send_byte(8'h55, 3);
    send_byte(8'h66, 3);
    checkOutput("err_no_wr", 32'(wr_addr_log.size() - wb), 0);
    checkOutput("err_no_rd", 32'(rd_addr_log.size() - rb), 0);
    checkOutput("err_no_tx", 32'(tx_log.size() - tb0), 0);
    checkOutput("err_busy", 32'(bus.Busy), 1);
    end_frame();
    checkOutput("err_exit_busy", 32'(bus.Busy), 0);
    checkOutput("err_sticky", 32'(bus.Err_Flag), 1);
    start_frame();
    checkOutput("err_cleared", 32'(bus.Err_Flag), 0);
    end_frame();

    $display("[TB] overruns");
    rb = rd_addr_log.size();
    start_frame();
    send_byte(8'h83, 0);
    send_byte(8'hAA, 1);
    checkOutput("ovr_req_no_rd", 32'(rd_addr_log.size() - rb), 0);
    checkOutput("ovr_req_err", 32'(bus.Err_Flag), 1);
    end_frame();
    tb0 = tx_log.size();
    start_frame();
    checkOutput("ovr_err_cleared", 32'(bus.Err_Flag), 0);
    send_byte(8'h84, 0);
    wait_rd_en("ovr", found);
    send_byte(8'hAB, 0);
    checkOutput("ovr_wait_err", 32'(bus.Err_Flag), 1);
    bus.Reg_Rd_Valid = 1'b1;
    bus.Reg_Rd_Data  = 8'h77;
    tick();
    bus.Reg_Rd_Valid = 1'b0;
    tick(); tick();
    checkOutput("ovr_late_rsp_ignored", 32'(tx_log.size() - tb0), 0);
    checkOutput("ovr_busy", 32'(bus.Busy), 1);
    end_frame();

    $display("[TB] command-only frame and byte on frame end");
    wb = wr_addr_log.size();
    rb = rd_addr_log.size();
    start_frame();
    send_byte(8'h45, 3);
    end_frame();
    checkOutput("cmdonly_no_wr", 32'(wr_addr_log.size() - wb), 0);
    checkOutput("cmdonly_no_rd", 32'(rd_addr_log.size() - rb), 0);
    checkOutput("cmdonly_err", 32'(bus.Err_Flag), 0);
    start_frame();
    send_byte(8'h00, 3);
    applyStimulus(1'b0, 1'b1, 8'h12);
    tick(); tick(); tick();
    checkOutput("drop_no_wr", 32'(wr_addr_log.size() - wb), 0);
    checkOutput("drop_idle", 32'(bus.Busy), 0);
    checkOutput("drop_err", 32'(bus.Err_Flag), 0);

    $display("[TB] frame counter wrap");
    need = 8'd255 - exp_frames;
    for (int i = 0; i < int'(need); i++) begin
      start_frame();
      end_frame();
    end
    checkOutput("frame_cnt_max", 32'(bus.Frame_Cnt), 32'hFF);
    start_frame();
    checkOutput("frame_cnt_wrap", 32'(bus.Frame_Cnt), 0);
    end_frame();

    $display("[TB] back-to-back frames then reset mid-frame");
    MRst_n = 1'b0;
    tick();
    MRst_n = 1'b1;
    tick();
    exp_frames = 8'h00;
    for (int i = 0; i < 2; i++) begin
      start_frame();
      send_byte(8'h45, 3);
      send_byte(8'h01, 3);
      end_frame();
    end
    start_frame();
    send_byte(8'h45, 3);
    checkOutput("b2b_frame_cnt", 32'(bus.Frame_Cnt), 3);
    checkOutput("b2b_addr_before", 32'(bus.Reg_Addr), 5);
    wb = wr_addr_log.size();
    bus.Rx_Valid = 1'b1;
    bus.Rx_Byte  = 8'h99;
    #2;
    MRst_n = 1'b0;
    #1;
    checkOutput("arst_busy",      32'(bus.Busy),        0);
    checkOutput("arst_err",       32'(bus.Err_Flag),    0);
    checkOutput("arst_frame_cnt", 32'(bus.Frame_Cnt),   0);
    checkOutput("arst_tx_byte",   32'(bus.Tx_Byte),     0);
    checkOutput("arst_addr",      32'(bus.Reg_Addr),    0);
    checkOutput("arst_wr_data",   32'(bus.Reg_Wr_Data), 0);
    checkOutput("arst_strobes",   32'({bus.Reg_Wr_En, bus.Reg_Rd_En, bus.Tx_Load}), 0);
    bus.Rx_Valid    = 1'b0;
    bus.Csel_Active = 1'b0;
    tick();
    tick();
    MRst_n = 1'b1;
    tick();
    tick();
    checkOutput("post_rst_no_wr", 32'(wr_addr_log.size() - wb), 0);
    checkOutput("post_rst_frame_cnt", 32'(bus.Frame_Cnt), 0);
    checkOutput("post_rst_busy", 32'(bus.Busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
